// File: rtl/cheat_pkg.sv
// cheat_pkg: shared command, response, state and slot types for the cheat engine
package cheat_pkg;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_DELETE = 2'd1, OP_CLEAR = 2'd2, OP_NOP = 2'd3} cmd_op_e;
  typedef enum logic [1:0] {RSP_OK = 2'd0, RSP_FULL = 2'd1, RSP_NOTFOUND = 2'd2} rsp_status_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SCAN = 2'd1, ST_COMMIT = 2'd2} state_e;
  localparam int FLAG_CMP = 0;
  localparam int FLAG_DIS = 1;
  typedef struct packed {
    logic        vld;
    logic        cmp;
    logic        dis;
    logic [31:0] addr;
    logic [31:0] cmp_data;
    logic [31:0] rep;
  } slot_t;
  function automatic slot_t make_slot(input logic [127:0] code);
    slot_t s;
    s.vld      = 1'b1;
    s.cmp      = code[96+FLAG_CMP];
    s.dis      = code[96+FLAG_DIS];
    s.addr     = code[95:64];
    s.cmp_data = code[63:32];
    s.rep      = code[31:0];
    return s;
  endfunction
endpackage

// File: rtl/cheat_match.sv
// cheat_match: per-channel lowest-index priority match over the code table
module cheat_match #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CODES  = 32
) (
  input  logic                                 enable,
  input  logic [ADDR_WIDTH-1:0]                addr_in,
  input  logic [DATA_WIDTH-1:0]                data_in,
  input  logic [MAX_CODES-1:0]                 slot_vld,
  input  logic [MAX_CODES-1:0]                 slot_cmp,
  input  logic [MAX_CODES-1:0]                 slot_dis,
  input  logic [MAX_CODES-1:0][ADDR_WIDTH-1:0] slot_addr,
  input  logic [MAX_CODES-1:0][DATA_WIDTH-1:0] slot_data,
  input  logic [MAX_CODES-1:0][DATA_WIDTH-1:0] slot_rep,
  output logic                                 ovr,
  output logic [DATA_WIDTH-1:0]                data_out
);
  always_comb begin
    ovr      = 1'b0;
    data_out = '0;
    for (int i = MAX_CODES - 1; i >= 0; i--)
      if (enable && slot_vld[i] && !slot_dis[i] && slot_addr[i] == addr_in &&
          (!slot_cmp[i] || slot_data[i] == data_in)) begin
        ovr      = 1'b1;
        data_out = slot_rep[i];
      end
  end
endmodule

// File: rtl/cheat_engine.sv
// cheat_engine: command-driven code table with scan FSM and per-channel read-data override
module cheat_engine import cheat_pkg::*; #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_CODES  = 32,
  parameter int CHANNELS   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_op,
  input  logic [127:0]                   cmd_code,
  output logic                           rsp_valid,
  output logic [1:0]                     rsp_status,
  output logic [$clog2(MAX_CODES):0]     code_count,
  output logic                           full,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] addr_in,
  input  logic [CHANNELS*DATA_WIDTH-1:0] data_in,
  output logic [CHANNELS-1:0]            genie_ovr,
  output logic [CHANNELS*DATA_WIDTH-1:0] genie_data
);
  localparam int IW = $clog2(MAX_CODES);
  localparam int CW = IW + 1;
  state_e                                state_q, state_d;
  cmd_op_e                               op_q, op_d;
  rsp_status_e                           rsp_status_q, rsp_status_d;
  slot_t                                 cs;
  logic [ADDR_WIDTH-1:0]                 c_addr_q, c_addr_d;
  logic [DATA_WIDTH-1:0]                 c_cmpd_q, c_cmpd_d, c_rep_q, c_rep_d;
  logic                                  c_cmpf_q, c_cmpf_d, c_dis_q, c_dis_d;
  logic [IW-1:0]                         idx_q, idx_d, dup_idx_q, dup_idx_d, free_idx_q, free_idx_d, wr_idx;
  logic                                  dup_q, dup_d, free_q, free_d, dup_hit, free_hit;
  logic                                  cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d;
  logic [CW-1:0]                         count_q, count_d;
  logic [MAX_CODES-1:0]                  slot_vld_q, slot_vld_d, slot_cmp_q, slot_cmp_d, slot_dis_q, slot_dis_d;
  logic [MAX_CODES-1:0][ADDR_WIDTH-1:0]  slot_addr_q, slot_addr_d;
  logic [MAX_CODES-1:0][DATA_WIDTH-1:0]  slot_data_q, slot_data_d, slot_rep_q, slot_rep_d;
  always_comb begin
    cs           = make_slot(cmd_code);
    state_d      = state_q;
    op_d         = op_q;
    c_addr_d     = c_addr_q;
    c_cmpd_d     = c_cmpd_q;
    c_rep_d      = c_rep_q;
    c_cmpf_d     = c_cmpf_q;
    c_dis_d      = c_dis_q;
    idx_d        = idx_q;
    dup_d        = dup_q;
    dup_idx_d    = dup_idx_q;
    free_d       = free_q;
    free_idx_d   = free_idx_q;
    cmd_ready_d  = cmd_ready_q;
    rsp_valid_d  = 1'b0;
    rsp_status_d = rsp_status_q;
    count_d      = count_q;
    slot_vld_d   = slot_vld_q;
    slot_cmp_d   = slot_cmp_q;
    slot_dis_d   = slot_dis_q;
    slot_addr_d  = slot_addr_q;
    slot_data_d  = slot_data_q;
    slot_rep_d   = slot_rep_q;
    dup_hit      = slot_vld_q[idx_q] && slot_addr_q[idx_q] == c_addr_q;
    free_hit     = !slot_vld_q[idx_q];
    wr_idx       = dup_q ? dup_idx_q : free_idx_q;
    if (state_q == ST_IDLE) begin
      if (cmd_valid) begin
        op_d         = cmd_op_e'(cmd_op);
        c_addr_d     = cs.addr[ADDR_WIDTH-1:0];
        c_cmpd_d     = cs.cmp_data[DATA_WIDTH-1:0];
        c_rep_d      = cs.rep[DATA_WIDTH-1:0];
        c_cmpf_d     = cs.cmp;
        c_dis_d      = cs.dis;
        idx_d        = '0;
        dup_d        = 1'b0;
        free_d       = 1'b0;
        cmd_ready_d  = 1'b0;
        state_d      = cmd_op[1] ? ST_COMMIT : ST_SCAN;
        rsp_valid_d  = cmd_op[1];
        rsp_status_d = RSP_OK;
      end
    end else if (state_q == ST_SCAN) begin
      if (dup_hit && !dup_q) begin
        dup_d     = 1'b1;
        dup_idx_d = idx_q;
      end
      if (free_hit && !free_q) begin
        free_d     = 1'b1;
        free_idx_d = idx_q;
      end
      idx_d = idx_q + IW'(1);
      if (idx_q == IW'(MAX_CODES - 1)) begin
        state_d      = ST_COMMIT;
        rsp_valid_d  = 1'b1;
        rsp_status_d = dup_d ? RSP_OK : op_q != OP_ADD ? RSP_NOTFOUND : free_d ? RSP_OK : RSP_FULL;
      end
    end else begin
      state_d     = ST_IDLE;
      cmd_ready_d = 1'b1;
      if (op_q == OP_CLEAR) begin
        slot_vld_d = '0;
        count_d    = '0;
      end else if (op_q == OP_ADD && (dup_q || free_q)) begin
        slot_vld_d[wr_idx]  = 1'b1;
        slot_cmp_d[wr_idx]  = c_cmpf_q;
        slot_dis_d[wr_idx]  = c_dis_q;
        slot_addr_d[wr_idx] = c_addr_q;
        slot_data_d[wr_idx] = c_cmpd_q;
        slot_rep_d[wr_idx]  = c_rep_q;
        count_d             = dup_q ? count_q : count_q + CW'(1);
      end else if (op_q == OP_DELETE && dup_q) begin
        slot_vld_d[dup_idx_q] = 1'b0;
        count_d               = count_q - CW'(1);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      op_q         <= OP_NOP;
      rsp_status_q <= RSP_OK;
      c_addr_q     <= '0;
      c_cmpd_q     <= '0;
      c_rep_q      <= '0;
      c_cmpf_q     <= 1'b0;
      c_dis_q      <= 1'b0;
      idx_q        <= '0;
      dup_q        <= 1'b0;
      dup_idx_q    <= '0;
      free_q       <= 1'b0;
      free_idx_q   <= '0;
      cmd_ready_q  <= 1'b1;
      rsp_valid_q  <= 1'b0;
      count_q      <= '0;
      slot_vld_q   <= '0;
      slot_cmp_q   <= '0;
      slot_dis_q   <= '0;
      slot_addr_q  <= '0;
      slot_data_q  <= '0;
      slot_rep_q   <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      rsp_status_q <= rsp_status_d;
      c_addr_q     <= c_addr_d;
      c_cmpd_q     <= c_cmpd_d;
      c_rep_q      <= c_rep_d;
      c_cmpf_q     <= c_cmpf_d;
      c_dis_q      <= c_dis_d;
      idx_q        <= idx_d;
      dup_q        <= dup_d;
      dup_idx_q    <= dup_idx_d;
      free_q       <= free_d;
      free_idx_q   <= free_idx_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      count_q      <= count_d;
      slot_vld_q   <= slot_vld_d;
      slot_cmp_q   <= slot_cmp_d;
      slot_dis_q   <= slot_dis_d;
      slot_addr_q  <= slot_addr_d;
      slot_data_q  <= slot_data_d;
      slot_rep_q   <= slot_rep_d;
    end
  end
  assign cmd_ready  = cmd_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_status = rsp_status_q;
  assign code_count = count_q;
  assign full       = count_q == CW'(MAX_CODES);
  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cheat_match #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH), .MAX_CODES(MAX_CODES)) u_match (
      .enable   (enable),
      .addr_in  (addr_in[c*ADDR_WIDTH +: ADDR_WIDTH]),
      .data_in  (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
      .slot_vld (slot_vld_q),
      .slot_cmp (slot_cmp_q),
      .slot_dis (slot_dis_q),
      .slot_addr(slot_addr_q),
      .slot_data(slot_data_q),
      .slot_rep (slot_rep_q),
      .ovr      (genie_ovr[c]),
      .data_out (genie_data[c*DATA_WIDTH +: DATA_WIDTH])
    );
  end
endmodule

// File: tb/tb_cheat_engine.sv
// tb_cheat_engine: directed self-checking bench for the cheat engine
module tb_cheat_engine;
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         enable = 1'b1;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic [1:0]   cmd_op = 2'd3;
  logic [127:0] cmd_code = '0;
  logic         rsp_valid;
  logic [1:0]   rsp_status;
  logic [5:0]   code_count;
  logic         full;
  logic [31:0]  addr_in = '0;
  logic [15:0]  data_in = '0;
  logic [1:0]   genie_ovr;
  logic [15:0]  genie_data;
  int           checks = 0;
  int           failures = 0;
  int           seen;
  cheat_engine u_dut (
    .clk(clk), .reset(reset), .enable(enable), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_code(cmd_code), .rsp_valid(rsp_valid), .rsp_status(rsp_status),
    .code_count(code_count), .full(full), .addr_in(addr_in), .data_in(data_in),
    .genie_ovr(genie_ovr), .genie_data(genie_data)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [127:0] mk(input logic [31:0] f, input logic [31:0] a, input logic [31:0] c, input logic [31:0] r);
    return {f, a, c, r};
  endfunction
  task automatic do_cmd(input string tag, input logic [1:0] op, input logic [127:0] code,
                        input logic [1:0] est, input int elat, input int ecnt);
    int n;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_code  = code;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 1;
    @(negedge clk);
    while (!rsp_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'(elat));
    check({tag, "_status"}, 64'(rsp_status), 64'(est));
    @(negedge clk);
    check({tag, "_pulse"}, 64'(rsp_valid), 64'd0);
    check({tag, "_count"}, 64'(code_count), 64'(ecnt));
  endtask
  task automatic look(input string tag, input logic [15:0] a0, input logic [7:0] d0,
                      input logic [15:0] a1, input logic [7:0] d1,
                      input logic [1:0] eovr, input logic [15:0] edata);
    addr_in = {a1, a0};
    data_in = {d1, d0};
    #1;
    check({tag, "_ovr"}, 64'(genie_ovr), 64'(eovr));
    check({tag, "_data"}, 64'(genie_data), 64'(edata));
  endtask
  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_status", 64'(rsp_status), 64'd0);
    check("rst_count", 64'(code_count), 64'd0);
    check("rst_full", 64'(full), 64'd0);
    look("rst_look", 16'h0150, 8'h00, 16'h0151, 8'h00, 2'b00, 16'h0000);
    do_cmd("add150", 2'd0, mk(0, 32'h0150, 0, 32'h3C), 2'd0, 33, 1);
    look("hit150", 16'h0150, 8'h00, 16'h0151, 8'h00, 2'b01, 16'h003C);
    do_cmd("add2000", 2'd0, mk(1, 32'h2000, 32'h11, 32'h99), 2'd0, 33, 2);
    look("both_hit", 16'h0150, 8'h00, 16'h2000, 8'h11, 2'b11, 16'h993C);
    look("cmp_miss", 16'h0150, 8'h00, 16'h2000, 8'h12, 2'b01, 16'h003C);
    enable = 1'b0;
    look("disabled", 16'h0150, 8'h00, 16'h2000, 8'h11, 2'b00, 16'h0000);
    enable = 1'b1;
    do_cmd("dup150", 2'd0, mk(0, 32'h0150, 0, 32'h55), 2'd0, 33, 2);
    look("hit_dup", 16'h0150, 8'h00, 16'hFFFF, 8'h00, 2'b01, 16'h0055);
    do_cmd("del150", 2'd1, mk(0, 32'h0150, 0, 0), 2'd0, 33, 1);
    look("gone150", 16'h0150, 8'h00, 16'h2000, 8'h11, 2'b10, 16'h9900);
    do_cmd("del150b", 2'd1, mk(0, 32'h0150, 0, 0), 2'd2, 33, 1);
    do_cmd("clr1", 2'd2, '0, 2'd0, 1, 0);
    look("clr1_look", 16'h0150, 8'h00, 16'h2000, 8'h11, 2'b00, 16'h0000);
    for (int i = 0; i < 32; i++)
      do_cmd($sformatf("fill%0d", i), 2'd0, mk(0, 32'h1000 + i, 0, i), 2'd0, 33, i + 1);
    check("fill_full", 64'(full), 64'd1);
    do_cmd("over", 2'd0, mk(0, 32'h3000, 0, 32'h77), 2'd1, 33, 32);
    look("over_look", 16'h3000, 8'h00, 16'h1005, 8'h00, 2'b10, 16'h0500);
    do_cmd("del1005", 2'd1, mk(0, 32'h1005, 0, 0), 2'd0, 33, 31);
    check("hole_full", 64'(full), 64'd0);
    do_cmd("add4000", 2'd0, mk(0, 32'h4000, 0, 32'hAB), 2'd0, 33, 32);
    check("refill_full", 64'(full), 64'd1);
    look("hole_look", 16'h4000, 8'h00, 16'h1005, 8'h00, 2'b01, 16'h00AB);
    do_cmd("over2", 2'd0, mk(0, 32'h4001, 0, 32'h01), 2'd1, 33, 32);
    do_cmd("ovw_full", 2'd0, mk(0, 32'h1006, 0, 32'hEE), 2'd0, 33, 32);
    look("ovw_look", 16'h1006, 8'h00, 16'h101F, 8'h00, 2'b11, 16'h1FEE);
    do_cmd("clr2", 2'd2, '0, 2'd0, 1, 0);
    check("clr2_full", 64'(full), 64'd0);
    look("clr2_look", 16'h4000, 8'h00, 16'h1006, 8'h00, 2'b00, 16'h0000);
    do_cmd("add_dis", 2'd0, mk(2, 32'h5000, 0, 32'h77), 2'd0, 33, 1);
    look("dis_look", 16'h5000, 8'h00, 16'h5000, 8'h00, 2'b00, 16'h0000);
    do_cmd("nop", 2'd3, '0, 2'd0, 1, 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'd0;
    cmd_code  = mk(0, 32'h6000, 0, 32'h66);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (10) @(negedge clk);
    check("scan_busy", 64'(cmd_ready), 64'd0);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", 64'(cmd_ready), 64'd1);
    check("mid_rst_count", 64'(code_count), 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      seen += int'(rsp_valid);
      @(negedge clk);
    end
    check("mid_rst_no_rsp", 64'(seen), 64'd0);
    look("mid_rst_look", 16'h6000, 8'h00, 16'h5000, 8'h00, 2'b00, 16'h0000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
